// File: rtl/radio_pkg.sv
// Shared sample types for the radio datapath.
// Stream fork/join blocks import this package.
package radio_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  // Decimation factor must be >= 1 and fit the counter.
  function automatic bit decim_ok(int decim, int cnt_w);
    return (decim >= 1) &&
           ((longint'(1) << cnt_w) >= longint'(decim));
  endfunction

endpackage

// File: rtl/split_two_outputs_if.sv
// FIFO-side signals of the two-output stream fork.
// master = fork, slave = surrounding FIFOs.
interface split_two_outputs_if #(
  parameter int DATA_WIDTH = 32
);

  logic                         in_rd_en;
  logic                         in_empty;
  logic signed [DATA_WIDTH-1:0] in_dout;
  logic                         outA_wr_en;
  logic                         outA_full;
  logic signed [DATA_WIDTH-1:0] outA_din;
  logic                         outB_wr_en;
  logic                         outB_full;
  logic signed [DATA_WIDTH-1:0] outB_din;
  logic                         busy;

  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output outA_wr_en,
    input  outA_full,
    output outA_din,
    output outB_wr_en,
    input  outB_full,
    output outB_din,
    output busy
  );

  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  outA_wr_en,
    output outA_full,
    input  outA_din,
    input  outB_wr_en,
    output outB_full,
    input  outB_din,
    input  busy
  );

endinterface

// File: rtl/out_hold_stage.sv
// One-entry holding stage in front of a FIFO.
// A stage that drains this cycle counts as free.
module out_hold_stage
  import radio_pkg::*;
#(
  parameter int DATA_WIDTH = radio_pkg::DATA_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load,
  input  logic signed [DATA_WIDTH-1:0] load_data,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic signed [DATA_WIDTH-1:0] out_din,
  output logic                         free,
  output logic                         valid
);

  logic signed [DATA_WIDTH-1:0] data_q;

  assign out_wr_en = valid & ~out_full;
  assign out_din   = data_q;
  assign free      = ~valid | out_wr_en;

  // Load beats drain; a full FIFO holds the sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      data_q <= load_data;
    end else if (out_wr_en) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/split_two_outputs.sv
// Stream fork: A gets every sample, B every
// DECIM_B-th sample, each behind its own hold stage.
module split_two_outputs
  import radio_pkg::*;
#(
  parameter int DATA_WIDTH = radio_pkg::DATA_WIDTH,
  parameter int DECIM_B    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                clock,
  input  logic                reset,
  split_two_outputs_if.master bus
);

  if (!decim_ok(DECIM_B, CNT_WIDTH)) begin : g_bad_cfg
    $fatal(1, "split_two_outputs: bad DECIM_B/CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DECIM_B - 1);

  logic [CNT_WIDTH-1:0] dec_cnt;
  logic                 take_b;
  logic                 rd;
  logic                 a_free;
  logic                 b_free;
  logic                 a_valid;
  logic                 b_valid;

  assign take_b = (dec_cnt == '0);

  // Pop only if A can take it, and B too when
  // this sample belongs to the decimated branch.
  assign rd = ~bus.in_empty & a_free &
              (b_free | ~take_b);

  assign bus.in_rd_en = rd;
  assign bus.busy     = a_valid | b_valid;

  out_hold_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold_a (
    .clock     (clock),
    .reset     (reset),
    .load      (rd),
    .load_data (bus.in_dout),
    .out_full  (bus.outA_full),
    .out_wr_en (bus.outA_wr_en),
    .out_din   (bus.outA_din),
    .free      (a_free),
    .valid     (a_valid)
  );

  out_hold_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold_b (
    .clock     (clock),
    .reset     (reset),
    .load      (rd & take_b),
    .load_data (bus.in_dout),
    .out_full  (bus.outB_full),
    .out_wr_en (bus.outB_wr_en),
    .out_din   (bus.outB_din),
    .free      (b_free),
    .valid     (b_valid)
  );

  // Decimation phase advances once per popped sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dec_cnt <= '0;
    end else if (rd) begin
      dec_cnt <= (dec_cnt == LAST) ? '0 :
                 dec_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_split_two_outputs.sv
// Bench for split_two_outputs: DECIM_B=1 and
// DECIM_B=4 instances with a queue scoreboard.
module tb_split_two_outputs;
  import radio_pkg::*;

  typedef struct {
    sample_t d;
    bit      to_b;
  } in_t;

  typedef struct {
    int      dut;
    sample_t din;
    bit      exp_b;
  } vec_t;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  split_two_outputs_if #(.DATA_WIDTH(DATA_WIDTH)) bus1 ();
  split_two_outputs_if #(.DATA_WIDTH(DATA_WIDTH)) bus4 ();

  split_two_outputs #(
    .DATA_WIDTH(DATA_WIDTH), .DECIM_B(1), .CNT_WIDTH(16)
  ) u_d1 (.clock(clock), .reset(reset), .bus(bus1));

  split_two_outputs #(
    .DATA_WIDTH(DATA_WIDTH), .DECIM_B(4), .CNT_WIDTH(16)
  ) u_d4 (.clock(clock), .reset(reset), .bus(bus4));

  logic [1:0] empty_f, a_full, b_full, hold_empty;
  sample_t    dout [2];
  logic [1:0] rd, wa, wb, bz;
  sample_t    da [2];
  sample_t    db [2];

  assign bus1.in_empty  = empty_f[0];
  assign bus1.in_dout   = dout[0];
  assign bus1.outA_full = a_full[0];
  assign bus1.outB_full = b_full[0];
  assign bus4.in_empty  = empty_f[1];
  assign bus4.in_dout   = dout[1];
  assign bus4.outA_full = a_full[1];
  assign bus4.outB_full = b_full[1];

  assign rd[0] = bus1.in_rd_en;
  assign wa[0] = bus1.outA_wr_en;
  assign wb[0] = bus1.outB_wr_en;
  assign bz[0] = bus1.busy;
  assign da[0] = bus1.outA_din;
  assign db[0] = bus1.outB_din;
  assign rd[1] = bus4.in_rd_en;
  assign wa[1] = bus4.outA_wr_en;
  assign wb[1] = bus4.outB_wr_en;
  assign bz[1] = bus4.busy;
  assign da[1] = bus4.outA_din;
  assign db[1] = bus4.outB_din;

  in_t     inq  [2][$];
  sample_t expA [2][$];
  sample_t expB [2][$];
  sample_t gotB [2][$];
  int      pcA  [2][$];
  int      pcB  [2][$];
  bit      pop_pend [2];
  bit      chk_lat;
  int      cyc;
  int      ph4;
  int      total;
  int      bad;

  function automatic void chk(string nm,
                              logic signed [63:0] act,
                              logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  function automatic void refresh();
    for (int d = 0; d < 2; d++) begin
      empty_f[d] = hold_empty[d] || (inq[d].size() == 0);
      if (inq[d].size() != 0) dout[d] = inq[d][0].d;
    end
  endfunction

  function automatic void send(int d, sample_t v, bit to_b);
    in_t e;
    e.d    = v;
    e.to_b = to_b;
    inq[d].push_back(e);
    expA[d].push_back(v);
    if (to_b) expB[d].push_back(v);
    if (d == 1) ph4 = (ph4 == 3) ? 0 : ph4 + 1;
    refresh();
  endfunction

  function automatic void send_auto(int d, sample_t v);
    send(d, v, (d == 0) || (ph4 == 0));
  endfunction

  function automatic void chk_idle(int d, string nm);
    chk($sformatf("%s_rd%0d", nm, d), rd[d], 0);
    chk($sformatf("%s_wa%0d", nm, d), wa[d], 0);
    chk($sformatf("%s_wb%0d", nm, d), wb[d], 0);
    chk($sformatf("%s_da%0d", nm, d), da[d], 0);
    chk($sformatf("%s_db%0d", nm, d), db[d], 0);
    chk($sformatf("%s_bz%0d", nm, d), bz[d], 0);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: observe pops and writes away from the edge.
  always @(negedge clock) begin
    sample_t e;
    int      p;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        if (rd[d]) begin
          if (empty_f[d] || inq[d].size() == 0) begin
            chk($sformatf("rd_on_empty%0d", d), rd[d], 0);
          end else begin
            pcA[d].push_back(cyc);
            if (inq[d][0].to_b) pcB[d].push_back(cyc);
            pop_pend[d] <= 1'b1;
          end
        end
        if (wa[d]) begin
          if (expA[d].size() == 0) begin
            chk($sformatf("spur_A%0d", d), wa[d], 0);
          end else begin
            e = expA[d].pop_front();
            chk($sformatf("outA%0d", d), da[d], e);
            p = pcA[d].pop_front();
            if (chk_lat)
              chk($sformatf("latA%0d", d), cyc - p, 1);
          end
        end
        if (wb[d]) begin
          gotB[d].push_back(db[d]);
          if (expB[d].size() == 0) begin
            chk($sformatf("spur_B%0d", d), wb[d], 0);
          end else begin
            e = expB[d].pop_front();
            chk($sformatf("outB%0d", d), db[d], e);
            p = pcB[d].pop_front();
            if (chk_lat)
              chk($sformatf("latB%0d", d), cyc - p, 1);
          end
        end
      end
    end
  end

  // Input FIFO model: retire popped heads after the edge.
  always @(posedge clock) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (pop_pend[d]) begin
        void'(inq[d].pop_front());
        pop_pend[d] = 1'b0;
      end
    end
    refresh();
  end

  task automatic wait_drain(input int d, input int limit,
                            input string nm, output int n);
    n = 0;
    while (!(inq[d].size() == 0 && expA[d].size() == 0 &&
             expB[d].size() == 0) && n < limit) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk(nm, (inq[d].size() + expA[d].size() +
             expB[d].size()), 0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  vec_t tbl [15];
  bit [11:0] bpat;
  int n;

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    ph4 = 0;
    chk_lat = 1'b0;
    a_full = '0;
    b_full = '0;
    hold_empty = '0;
    dout[0] = '0;
    dout[1] = '0;
    pop_pend[0] = 1'b0;
    pop_pend[1] = 1'b0;
    reset = 1'b0;
    refresh();

    bpat = 12'b0001_0001_0001;
    tbl[0] = '{0, sample_t'(5), 1'b1};
    tbl[1] = '{0, sample_t'(-7), 1'b1};
    tbl[2] = '{0, sample_t'(2147483647), 1'b1};
    for (int i = 0; i < 12; i++)
      tbl[3 + i] = '{1, sample_t'(i), bpat[i]};

    #12;
    chk_idle(0, "rst");
    chk_idle(1, "rst");
    @(posedge clock);
    #2;
    reset = 1'b1;
    step(1);

    // Streams from the vector table, no backpressure.
    chk_lat = 1'b1;
    foreach (tbl[i]) send(tbl[i].dut, tbl[i].din, tbl[i].exp_b);
    wait_drain(0, 20, "t1_drain", n);
    chk("t1_cycles", n, 4);
    wait_drain(1, 40, "t2_drain", n);
    chk("t2_bcount", gotB[1].size(), 3);
    chk("t1_bcount", gotB[0].size(), 3);
    chk_lat = 1'b0;

    // A full stalls every input for 10 cycles.
    a_full[0] = 1'b1;
    send_auto(0, 3);
    send_auto(0, 4);
    send_auto(0, 5);
    step(1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t3_rd", rd[0], 0);
      chk("t3_hold", da[0], 3);
      chk("t3_wa", wa[0], 0);
    end
    a_full[0] = 1'b0;
    wait_drain(0, 20, "t3_drain", n);

    // B full: non-B samples flow until the next B sample.
    b_full[1] = 1'b1;
    for (int i = 20; i < 26; i++) send_auto(1, i);
    step(8);
    chk("t4_rd", rd[1], 0);
    chk("t4_inq", inq[1].size(), 2);
    chk("t4_expA", expA[1].size(), 2);
    chk("t4_wb", wb[1], 0);
    chk("t4_db", db[1], 20);
    b_full[1] = 1'b0;
    wait_drain(1, 20, "t4_drain", n);

    // Empty input with valid head data.
    hold_empty[1] = 1'b1;
    send_auto(1, 7);
    send_auto(1, 8);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_rd", rd[1], 0);
      chk("t5_wa", wa[1], 0);
      chk("t5_wb", wb[1], 0);
    end
    chk("t5_busy", bz[1], 0);
    hold_empty[1] = 1'b0;
    refresh();
    wait_drain(1, 20, "t5_drain", n);

    // Async reset between edges with both stages held.
    a_full[1] = 1'b1;
    b_full[1] = 1'b1;
    send_auto(1, 50);
    step(3);
    chk("t6_busy", bz[1], 1);
    reset = 1'b0;
    #1;
    chk_idle(1, "t6");
    #1;
    reset = 1'b1;
    inq[1].delete();
    expA[1].delete();
    expB[1].delete();
    pcA[1].delete();
    pcB[1].delete();
    gotB[1].delete();
    ph4 = 0;
    a_full[1] = 1'b0;
    b_full[1] = 1'b0;
    refresh();
    step(1);
    send_auto(1, 60);
    send_auto(1, 61);
    wait_drain(1, 20, "t6_drain", n);
    chk("t6_bcount", gotB[1].size(), 1);
    if (gotB[1].size() != 0)
      chk("t6_bfirst", gotB[1][0], 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/split_two_outputs.md
Name: split_two_outputs

Overview:
Stream fork, the counterpart of the two-input FIFO join blocks (divide/add/multiply). Reads one signed sample stream from an upstream FIFO and writes it to two downstream FIFOs. Output A receives every sample. Output B receives every DECIM_B-th sample, which feeds the decimated branch of the radio datapath. Each output has its own one-entry holding stage, so backpressure on one output stalls input only when that stage is occupied.

Parameters:
DATA_WIDTH, 32, sample width in bits; samples are passed through unmodified, signed.
DECIM_B, 1, output B takes sample indices 0, DECIM_B, 2*DECIM_B, ...; legal range 1..65535.
CNT_WIDTH, 16, width of the decimation counter; must satisfy 2**CNT_WIDTH >= DECIM_B.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low; 0 clears all state immediately, with no clock needed.
in_rd_en  out  1  pops the input FIFO; in_dout is first-word-fall-through.
in_empty  in  1  input FIFO empty.
in_dout  in  DATA_WIDTH  head sample of the input FIFO; valid whenever in_empty=0.
outA_wr_en  out  1  write strobe to FIFO A.
outA_full  in  1  FIFO A full.
outA_din  out  DATA_WIDTH  sample for FIFO A.
outB_wr_en  out  1  write strobe to FIFO B.
outB_full  in  1  FIFO B full.
outB_din  out  DATA_WIDTH  sample for FIFO B.
busy  out  1  1 when either holding stage holds a sample.

Behaviour:
- State: a_valid, a_data, b_valid, b_data, dec_cnt (0..DECIM_B-1).
- Reset (reset=0, asynchronous):
  - a_valid=b_valid=0, a_data=b_data=0, dec_cnt=0.
  - Hence in_rd_en=0, outA_wr_en=0, outB_wr_en=0, outA_din=outB_din=0, busy=0.
- Output drive (combinational from registers and full):
  - outA_wr_en = a_valid & ~outA_full; outA_din = a_data.
  - outB_wr_en = b_valid & ~outB_full; outB_din = b_data.
- Stage free: a_free = ~a_valid | outA_wr_en; b_free = ~b_valid | outB_wr_en. A stage draining this cycle counts as free.
- take_b = (dec_cnt == 0).
- in_rd_en = ~in_empty & a_free & (b_free | ~take_b). Combinational; never asserted while in_empty=1.
- On a rising edge with in_rd_en=1:
  - a_data <= in_dout; a_valid <= 1.
  - If take_b: b_data <= in_dout; b_valid <= 1.
  - dec_cnt <= (dec_cnt == DECIM_B-1) ? 0 : dec_cnt+1.
- On a rising edge with in_rd_en=0:
  - A stage that wrote this cycle clears its valid bit.
  - A stage that is stalled by full holds both valid and data unchanged.
- Simultaneous drain and load of one stage in the same cycle: the load wins, so valid stays 1 and the new data is captured.
- Latency: a sample popped at edge N is presented at edge N+1. Its write occurs at edge N+1 if the target is not full.
- Throughput: 1 sample/cycle with both outputs free.
- Input blocking:
  - Full on A blocks every input.
  - Full on B blocks input only when take_b=1 and b_valid=1 with no drain this cycle.
  - With DECIM_B>1, samples not destined for B flow while B is stalled.
- Ordering: each output preserves input order; no sample is dropped or duplicated.
- DECIM_B=1: take_b is always 1, so both outputs carry identical streams.
- Reset mid-operation: held samples are discarded. The decimation phase restarts at 0, so the first post-reset sample goes to B.
- dec_cnt wraps from DECIM_B-1 to 0; there is no other wrap.
- Elaboration: DECIM_B<1 or 2**CNT_WIDTH<DECIM_B is a $fatal.

Decomposition:
- Package radio_pkg: DATA_WIDTH constant and the typedef sample_t (logic signed [DATA_WIDTH-1:0]).
- Sub-module out_hold_stage, instantiated twice, one per output:
  - Inputs: clock, reset, load, load_data, out_full.
  - Outputs: out_wr_en, out_din, free, valid.
- The top level holds dec_cnt and the in_rd_en logic.

Test Plan:
- DECIM_B=1, input 5, -7, 2147483647, both outputs never full -> A and B each receive 5, -7, 2147483647. Each write occurs 1 cycle after its pop, with one pop per cycle.
- DECIM_B=4, input 0..11 -> A receives 0..11 and B receives 0, 4, 8. dec_cnt sequence 0,1,2,3,0,...
- DECIM_B=1, outA_full held high for 10 cycles after sample 3 loads -> A stage holds 3 for 10 cycles, in_rd_en=0 throughout, and no sample is lost once full deasserts.
- DECIM_B=4, outB_full held high while b_valid holds 0, samples 1..3 streaming -> samples 1, 2, 3 pop and reach A. in_rd_en drops at sample 4 until B drains.
- Input FIFO empty with valid head data -> in_rd_en stays 0 and no write strobes occur after the stages drain; busy falls to 0.
- reset pulsed low asynchronously mid-stream, between clock edges, with a_valid=b_valid=1 -> all outputs 0 immediately. The next sample after release goes to both A and B (dec_cnt=0).
